lcd_line_arbiter: RTL and testbench



---
 rtl/lcd_line_arbiter.sv | 141 ++++++++++++++
 tb/tb_lcd_line_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_arbiter.sv
// Round-robin arbiter that streams one of two 16-character lines into the
// character LCD write port, acknowledges it, then idles for HOLDOFF cycles.
module lcd_line_arbiter #(
   parameter int unsigned HOLDOFF = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req,
   input  logic [127:0] line0,
   input  logic         row0,
   input  logic [127:0] line1,
   input  logic         row1,
   output logic [1:0]   ack,
   output logic         busy,
   output logic [7:0]   lcd_data,
   output logic         lcd_en,
   output logic         lcd_row,
   output logic [3:0]   lcd_col
);

   typedef enum logic [1:0] {IDLE, SEND, DONE, HOLD} state_t;

   localparam logic [15:0] HOLD_LAST = 16'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

   state_t       state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         grant_q, grant_d;
   logic [127:0] line_q, line_d;
   logic         row_q, row_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [15:0]  hold_q, hold_d;
   logic [1:0]   ack_q, ack_d;
   logic         busy_q, busy_d;
   logic [7:0]   lcd_data_q, lcd_data_d;
   logic         lcd_en_q, lcd_en_d;
   logic         lcd_row_q, lcd_row_d;
   logic [3:0]   lcd_col_q, lcd_col_d;
   logic         gnt;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      line_d       = line_q;
      row_d        = row_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      ack_d        = 2'b00;
      lcd_data_d   = lcd_data_q;
      lcd_en_d     = 1'b0;
      lcd_row_d    = lcd_row_q;
      lcd_col_d    = lcd_col_q;
      gnt          = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               // Under contention the requester not served last wins
               gnt          = (req == 2'b11) ? ~last_grant_q : req[1];
               grant_d      = gnt;
               last_grant_d = gnt;
               line_d       = gnt ? line1 : line0;
               row_d        = gnt ? row1 : row0;
               cnt_d        = 4'd0;
               lcd_en_d     = 1'b1;
               lcd_col_d    = 4'd0;
               lcd_row_d    = row_d;
               lcd_data_d   = line_d[7:0];
               state_d      = SEND;
            end
         end
         SEND: begin
            // cnt_q is the column currently on the port; column 0 went out from IDLE
            if (cnt_q == 4'd15) begin
               cnt_d          = 4'd0;
               ack_d[grant_q] = 1'b1;
               state_d        = DONE;
            end else begin
               cnt_d      = cnt_q + 4'd1;
               lcd_en_d   = 1'b1;
               lcd_col_d  = cnt_d;
               lcd_data_d = line_q[{cnt_d, 3'b000} +: 8];
            end
         end
         DONE: begin
            hold_d  = 16'd0;
            state_d = (HOLDOFF == 0) ? IDLE : HOLD;
         end
         HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         line_q       <= '0;
         row_q        <= 1'b0;
         cnt_q        <= 4'd0;
         hold_q       <= 16'd0;
         ack_q        <= 2'b00;
         busy_q       <= 1'b0;
         lcd_data_q   <= 8'h00;
         lcd_en_q     <= 1'b0;
         lcd_row_q    <= 1'b0;
         lcd_col_q    <= 4'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         line_q       <= line_d;
         row_q        <= row_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         lcd_data_q   <= lcd_data_d;
         lcd_en_q     <= lcd_en_d;
         lcd_row_q    <= lcd_row_d;
         lcd_col_q    <= lcd_col_d;
      end
   end

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign lcd_data = lcd_data_q;
   assign lcd_en   = lcd_en_q;
   assign lcd_row  = lcd_row_q;
   assign lcd_col  = lcd_col_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed bench for lcd_line_arbiter: one instance with HOLDOFF=16, one with HOLDOFF=0.
module tb_lcd_line_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   req = 2'b00;
   logic [1:0]   req_z = 2'b00;
   logic [127:0] line0 = '0;
   logic [127:0] line1 = '0;
   logic         row0 = 1'b0;
   logic         row1 = 1'b0;

   logic [1:0]   ack, z_ack;
   logic         busy, z_busy;
   logic [7:0]   lcd_data, z_data;
   logic         lcd_en, z_en;
   logic         lcd_row, z_row;
   logic [3:0]   lcd_col, z_col;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] glip [16] = '{8'h67, 8'h6c, 8'h69, 8'h70, 8'h20, 8'h6c, 8'h6f, 8'h6f,
                             8'h70, 8'h62, 8'h61, 8'h63, 8'h6b, 8'h20, 8'h20, 8'h20};

   lcd_line_arbiter #(.HOLDOFF(16)) dut (
      .clk(clk), .rst(rst), .req(req),
      .line0(line0), .row0(row0), .line1(line1), .row1(row1),
      .ack(ack), .busy(busy), .lcd_data(lcd_data), .lcd_en(lcd_en),
      .lcd_row(lcd_row), .lcd_col(lcd_col)
   );

   lcd_line_arbiter #(.HOLDOFF(0)) dut0 (
      .clk(clk), .rst(rst), .req(req_z),
      .line0(line0), .row0(row0), .line1(line1), .row1(row1),
      .ack(z_ack), .busy(z_busy), .lcd_data(z_data), .lcd_en(z_en),
      .lcd_row(z_row), .lcd_col(z_col)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_idle(input bit sel);
      int n = 0;
      while (((sel ? z_busy : busy) !== 1'b0) && n < 200) begin
         tick;
         n++;
      end
      checks++;
      if ((sel ? z_busy : busy) !== 1'b0) begin
         failures++;
         $display("FAIL idle_timeout sel=%0d busy=%b expected 0", sel, sel ? z_busy : busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      checks++;
      if ({ack, busy, lcd_en, lcd_data, lcd_col, lcd_row} !== 17'h0) begin
         failures++;
         $display("FAIL reset_main got=%h expected 0", {ack, busy, lcd_en, lcd_data, lcd_col, lcd_row});
      end
      checks++;
      if ({z_ack, z_busy, z_en, z_data, z_col, z_row} !== 17'h0) begin
         failures++;
         $display("FAIL reset_hold0 got=%h expected 0", {z_ack, z_busy, z_en, z_data, z_col, z_row});
      end
      rst = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0 || lcd_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_req busy=%b en=%b expected 0 0", busy, lcd_en);
      end
   endtask

   task automatic test_single;
      for (int k = 0; k < 16; k++) line0[8*k +: 8] = glip[k];
      row0 = 1'b0;
      req = 2'b01;
      for (int k = 0; k < 16; k++) begin
         tick;
         checks++;
         if (lcd_en !== 1'b1 || lcd_col !== 4'(k) || lcd_row !== 1'b0 || lcd_data !== glip[k] || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_write col%0d got en=%b col=%0d row=%b data=%h busy=%b expected 1 %0d 0 %h 1",
                     k, lcd_en, lcd_col, lcd_row, lcd_data, busy, k, glip[k]);
         end
      end
      tick;
      checks++;
      if (ack !== 2'b01 || lcd_en !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_ack got ack=%b en=%b busy=%b expected 01 0 1", ack, lcd_en, busy);
      end
      req = 2'b00;
      repeat (16) tick;
      checks++;
      if (busy !== 1'b1 || ack !== 2'b00) begin
         failures++;
         $display("FAIL single_hold_end got busy=%b ack=%b expected 1 00", busy, ack);
      end
      tick;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_busy_fall got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_latching;
      for (int k = 0; k < 16; k++) line0[8*k +: 8] = 8'h10 + 8'(k);
      req = 2'b01;
      for (int k = 0; k < 16; k++) begin
         tick;
         checks++;
         if (lcd_en !== 1'b1 || lcd_data !== 8'h10 + 8'(k)) begin
            failures++;
            $display("FAIL latch_col%0d got en=%b data=%h expected 1 %h", k, lcd_en, lcd_data, 8'h10 + 8'(k));
         end
         if (k == 4) line0 = {16{8'h41}};
      end
      tick;
      checks++;
      if (ack !== 2'b01) begin
         failures++;
         $display("FAIL latch_ack got=%b expected 01", ack);
      end
      req = 2'b00;
      wait_idle(1'b0);
   endtask

   task automatic test_contention;
      int prev_ack = 0;
      int order [4] = '{0, 1, 0, 1};
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         line0[8*k +: 8] = glip[k];
         line1[8*k +: 8] = 8'h30 + 8'(k);
      end
      row0 = 1'b0;
      row1 = 1'b1;
      req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         tick;
         checks++;
         if (lcd_en !== 1'b1 || lcd_col !== 4'd0 || lcd_row !== order[g][0] ||
             lcd_data !== (order[g] == 1 ? 8'h30 : 8'h67)) begin
            failures++;
            $display("FAIL contend_first grant%0d got en=%b col=%0d row=%b data=%h expected requester %0d",
                     g, lcd_en, lcd_col, lcd_row, lcd_data, order[g]);
         end
         repeat (15) tick;
         checks++;
         if (lcd_en !== 1'b1 || lcd_col !== 4'd15 || lcd_data !== (order[g] == 1 ? 8'h3f : 8'h20)) begin
            failures++;
            $display("FAIL contend_last grant%0d got en=%b col=%0d data=%h expected 1 15 %h",
                     g, lcd_en, lcd_col, lcd_data, order[g] == 1 ? 8'h3f : 8'h20);
         end
         tick;
         checks++;
         if (ack !== (order[g] == 1 ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL contend_ack grant%0d got=%b expected requester %0d", g, ack, order[g]);
         end
         if (g > 0) begin
            checks++;
            if (cyc - prev_ack !== 34) begin
               failures++;
               $display("FAIL contend_spacing grant%0d got=%0d expected 34", g, cyc - prev_ack);
            end
         end
         prev_ack = cyc;
         req[order[g]] = 1'b0;
         tick;
         req[order[g]] = 1'b1;
         if (g < 3) repeat (16) tick;
      end
      req = 2'b00;
      wait_idle(1'b0);
   endtask

   task automatic test_reset_mid;
      int stray = 0;
      req = 2'b01;
      repeat (8) tick;
      rst = 1'b1;
      tick;
      checks++;
      if ({ack, busy, lcd_en, lcd_data, lcd_col, lcd_row} !== 17'h0) begin
         failures++;
         $display("FAIL reset_mid got=%h expected 0", {ack, busy, lcd_en, lcd_data, lcd_col, lcd_row});
      end
      rst = 1'b0;
      req = 2'b00;
      repeat (25) begin
         tick;
         if (ack !== 2'b00 || lcd_en !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL reset_mid_quiet got=%0d stray cycles expected 0", stray);
      end
      req = 2'b11;
      tick;
      checks++;
      if (lcd_en !== 1'b1 || lcd_row !== 1'b0 || lcd_data !== 8'h67) begin
         failures++;
         $display("FAIL reset_mid_regrant got en=%b row=%b data=%h expected 1 0 67", lcd_en, lcd_row, lcd_data);
      end
      repeat (16) tick;
      checks++;
      if (ack !== 2'b01) begin
         failures++;
         $display("FAIL reset_mid_ack got=%b expected 01", ack);
      end
      req = 2'b00;
      wait_idle(1'b0);
   endtask

   task automatic test_back_to_back;
      req_z = 2'b10;
      for (int k = 0; k < 16; k++) begin
         tick;
         checks++;
         if (z_en !== 1'b1 || z_col !== 4'(k) || z_row !== 1'b1 || z_data !== 8'h30 + 8'(k)) begin
            failures++;
            $display("FAIL b2b_write col%0d got en=%b col=%0d row=%b data=%h expected 1 %0d 1 %h",
                     k, z_en, z_col, z_row, z_data, k, 8'h30 + 8'(k));
         end
      end
      tick;
      checks++;
      if (z_ack !== 2'b10 || z_en !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ack got ack=%b en=%b expected 10 0", z_ack, z_en);
      end
      tick;
      checks++;
      if (z_en !== 1'b0 || z_busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got en=%b busy=%b expected 0 0", z_en, z_busy);
      end
      tick;
      checks++;
      if (z_en !== 1'b1 || z_col !== 4'd0 || z_data !== 8'h30) begin
         failures++;
         $display("FAIL b2b_regrant got en=%b col=%0d data=%h expected 1 0 30", z_en, z_col, z_data);
      end
      req_z = 2'b00;
      wait_idle(1'b1);
   endtask

   task automatic test_dropped;
      int writes = 0;
      req = 2'b01;
      for (int k = 0; k < 16; k++) begin
         tick;
         if (k == 0) req = 2'b00;
         if (lcd_en === 1'b1 && lcd_col === 4'(k) && lcd_data === glip[k]) writes++;
      end
      checks++;
      if (writes !== 16) begin
         failures++;
         $display("FAIL dropped_writes got=%0d expected 16", writes);
      end
      tick;
      checks++;
      if (ack !== 2'b01 || lcd_en !== 1'b0) begin
         failures++;
         $display("FAIL dropped_ack got ack=%b en=%b expected 01 0", ack, lcd_en);
      end
      wait_idle(1'b0);
   endtask

   initial begin
      test_reset;
      test_single;
      test_latching;
      test_contention;
      test_reset_mid;
      test_back_to_back;
      test_dropped;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycles=%0d expected completion", cyc);
      $fatal(1);
   end

endmodule
